// File: rtl/rs_pkg.sv
// Shared GF(2^8) definitions for the Reed-Solomon decoder front end.
// Field helpers here are evaluated at elaboration to build per-lane constants.
package rs_pkg;

  localparam int unsigned GF_M     = 8;
  localparam int unsigned GF_ORDER = 255;
  localparam logic [GF_M-1:0] GF_POLY = 8'h1D;

  function automatic int unsigned nsynd(input int unsigned t);
    return 2 * t;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Multiply by alpha: shift and fold the x^8 term back through the polynomial
  function automatic logic [GF_M-1:0] gf_xtime(input logic [GF_M-1:0] a);
    return {a[GF_M-2:0], 1'b0} ^ (a[GF_M-1] ? GF_POLY : GF_M'(0));
  endfunction

  function automatic logic [GF_M-1:0] gf_alpha_pow(input int unsigned k);
    logic [GF_M-1:0] a;
    a = GF_M'(1);
    for (int unsigned j = 0; j < (k % GF_ORDER); j++) begin
      a = gf_xtime(a);
    end
    return a;
  endfunction

endpackage

// File: rtl/gf2m8_multi.sv
// Combinational GF(2^8) multiplier, shift-and-add with reduction by GF_POLY.
module gf2m8_multi
  import rs_pkg::*;
(
  input  logic [GF_M-1:0] a,
  input  logic [GF_M-1:0] b,
  output logic [GF_M-1:0] p_c
);

  logic [GF_M-1:0] sh;

  always_comb begin
    p_c = '0;
    sh  = a;
    for (int i = 0; i < int'(GF_M); i++) begin
      if (b[i]) p_c = p_c ^ sh;
      sh = gf_xtime(sh);
    end
  end

endmodule

// File: rtl/rs_synd_lane.sv
// One syndrome lane: Horner accumulator multiplying by alpha^EXP each symbol.
module rs_synd_lane
  import rs_pkg::*;
#(
  parameter int unsigned EXP = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            restart,
  input  logic [GF_M-1:0] din,
  output logic [GF_M-1:0] acc_nxt_c
);

  localparam logic [GF_M-1:0] COEF = gf_alpha_pow(EXP);

  logic [GF_M-1:0] acc;
  logic [GF_M-1:0] prod_c;

  gf2m8_multi u_mul (
    .a   (acc),
    .b   (COEF),
    .p_c (prod_c)
  );

  // First symbol of a codeword overwrites, so no clear cycle is needed
  always_comb begin
    acc_nxt_c = restart ? din : (prod_c ^ din);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_nxt_c;
    end
  end

endmodule

// File: rtl/rs_syndrome.sv
// RS syndrome calculator: 2T Horner lanes, symbol counter and a one-deep
// valid/ready output register feeding the key-equation solver.
module rs_syndrome
  import rs_pkg::*;
#(
  parameter  int unsigned N    = 255,
  parameter  int unsigned T    = 8,
  parameter  int unsigned FCR  = 0,
  localparam int unsigned NS   = nsynd(T),
  localparam int unsigned SW   = NS * GF_M
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [GF_M-1:0] in_data,
  output logic            in_ready,
  output logic            synd_valid,
  input  logic            synd_ready,
  output logic [SW-1:0]   synd,
  output logic            err_flag
);

  localparam int unsigned CNT_W = cnt_width(N);

  logic [CNT_W-1:0] cnt;
  logic             first_c;
  logic             last_c;
  logic             accept_c;
  logic             load_c;
  logic [SW-1:0]    nxt_c;

  always_comb begin
    first_c  = (cnt == '0);
    last_c   = (cnt == CNT_W'(N - 1));
    // Only the closing symbol waits on a full output register
    in_ready = !(last_c && synd_valid && !synd_ready);
    accept_c = in_valid && in_ready;
    load_c   = accept_c && last_c;
  end

  for (genvar i = 0; i < int'(NS); i++) begin : g_lane
    rs_synd_lane #(
      .EXP (FCR + i)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .en        (accept_c),
      .restart   (first_c),
      .din       (in_data),
      .acc_nxt_c (nxt_c[GF_M*i +: GF_M])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept_c) begin
      cnt <= last_c ? '0 : cnt + CNT_W'(1);
    end
  end

  // A load wins over a drain in the same cycle, keeping valid high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      synd_valid <= 1'b0;
      synd       <= '0;
      err_flag   <= 1'b0;
    end else if (load_c) begin
      synd_valid <= 1'b1;
      synd       <= nxt_c;
      err_flag   <= |nxt_c;
    end else if (synd_ready) begin
      synd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rs_syndrome.sv
// Scoreboard bench for rs_syndrome: expected syndromes come from direct
// polynomial evaluation over GF(2^8) with a power table.
module tb_rs_syndrome;

  localparam int unsigned N   = 255;
  localparam int unsigned T   = 8;
  localparam int unsigned FCR = 0;
  localparam int unsigned NS  = 2 * T;
  localparam int unsigned SW  = 8 * NS;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          synd_valid;
  logic          synd_ready;
  logic [SW-1:0] synd;
  logic          err_flag;

  rs_syndrome #(.N(N), .T(T), .FCR(FCR)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .synd_valid (synd_valid),
    .synd_ready (synd_ready),
    .synd       (synd),
    .err_flag   (err_flag)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [SW-1:0] sq[$];
  logic [7:0]    r[0:N-1];
  logic [7:0]    pw[0:254];
  logic          rr_en = 1'b0;

  task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11D << (i - 8));
    return p[7:0];
  endfunction

  // S_i = sum_j r_j * alpha^((FCR+i)*j)
  function automatic logic [SW-1:0] model();
    logic [SW-1:0] s;
    logic [7:0]    acc;
    s = '0;
    for (int i = 0; i < int'(NS); i++) begin
      acc = 8'h00;
      for (int j = 0; j < int'(N); j++)
        acc = acc ^ gf_mul(r[j], pw[((FCR + i) * j) % 255]);
      s[8*i +: 8] = acc;
    end
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input logic [7:0] d, output int waits);
    logic ok;
    ok = 1'b0;
    waits = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      waits++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: got 0 expected 1 within 1000 cycles");
    end
  endtask

  task automatic send_range(input int hi, input int lo, input bit gaps, output int wt);
    int w;
    wt = 0;
    for (int j = hi; j >= lo; j--) begin
      if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
      send_sym(r[j], w);
      wt += w;
    end
  endtask

  task automatic fill(input int mode);
    for (int j = 0; j < int'(N); j++) r[j] = (mode == 3) ? 8'($urandom) : 8'h00;
    if (mode == 1) r[0] = 8'h01;
    if (mode == 2) r[N-1] = 8'h01;
  endtask

  // Monitor: each negedge with valid&&ready precedes exactly one handshake
  always @(negedge clk) begin
    if (!rst && synd_valid && synd_ready) begin
      if (sq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got %h expected none", synd);
      end else begin
        logic [SW-1:0] e;
        e = sq.pop_front();
        chk("synd", synd, e);
        chk("err_flag", SW'(err_flag), SW'(|e));
      end
    end
  end

  always @(posedge clk) begin
    if (rr_en) begin
      #1;
      synd_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [SW-1:0] ea, eb, all1;
    int wt;
    pw[0] = 8'h01;
    for (int k = 1; k < 255; k++) pw[k] = gf_mul(pw[k-1], 8'h02);
    all1 = '0;
    for (int i = 0; i < int'(NS); i++) all1[8*i +: 8] = 8'h01;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; synd_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", SW'(synd_valid), '0);
    chk("rst_synd", synd, '0);
    chk("rst_err", SW'(err_flag), '0);
    chk("rst_in_ready", SW'(in_ready), SW'(1));
    step();

    // All-zero codeword and one-cycle latency
    fill(0); sq.push_back(model());
    send_range(N - 1, 0, 1'b0, wt);
    @(negedge clk);
    chk("latency_valid", SW'(synd_valid), SW'(1));
    step();

    fill(1); sq.push_back(all1);
    send_range(N - 1, 0, 1'b0, wt);
    step();

    fill(2); sq.push_back(model());
    send_range(N - 1, 0, 1'b0, wt);
    @(negedge clk);
    chk("high_coef_s0_s3", SW'(synd[31:0]), SW'(32'hAD478E01));
    step();

    // Backpressure: two codewords back-to-back with synd_ready low
    synd_ready = 1'b0;
    fill(3); ea = model(); sq.push_back(ea);
    send_range(N - 1, 0, 1'b0, wt);
    @(negedge clk);
    chk("bp_first_valid", SW'(synd_valid), SW'(1));
    step();
    fill(3); eb = model(); sq.push_back(eb);
    send_range(N - 1, 1, 1'b0, wt);
    chk("bp_no_early_stall", SW'(wt), '0);
    in_valid = 1'b1; in_data = r[0];
    @(negedge clk);
    chk("bp_stall_last", SW'(in_ready), '0);
    chk("bp_hold_first", synd, ea);
    step(); step(); step();
    @(negedge clk);
    chk("bp_still_stalled", SW'(in_ready), '0);
    step();
    synd_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", SW'(in_ready), SW'(1));
    step();
    in_valid = 1'b0; synd_ready = 1'b0;
    @(negedge clk);
    chk("bp_valid_kept", SW'(synd_valid), SW'(1));
    chk("bp_second_loaded", synd, eb);
    step();
    synd_ready = 1'b1;
    step();

    // Reset mid-codeword discards partial input
    fill(3);
    send_range(N - 1, N - 100, 1'b0, wt);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", SW'(synd_valid), '0);
    chk("mid_rst_synd", synd, '0);
    chk("mid_rst_cnt", SW'(dut.cnt), '0);
    step();
    rst = 1'b0;
    step();
    fill(1); sq.push_back(all1);
    send_range(N - 1, 0, 1'b0, wt);
    step();

    // Random codewords with input gaps and random backpressure
    rr_en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      fill(3); sq.push_back(model());
      send_range(N - 1, 0, 1'b1, wt);
    end
    rr_en = 1'b0;
    step(); step();
    synd_ready = 1'b1;
    for (int k = 0; k < 2000 && sq.size() != 0; k++) step();
    step();
    chk("queue_empty", SW'(sq.size()), '0);
    chk("final_valid", SW'(synd_valid), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
